// File: rtl/alu_sequencer_if.sv
// Command handshake, ALU drive/return lines and architectural status of the ALU sequencer.
// The master side is the command source together with the combinational ALU it fronts.
interface alu_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_data;

    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_ci;
    logic       alu_nb;
    logic       alu_ic;
    logic       alu_na;
    logic       alu_xo;
    logic       alu_no;
    logic       alu_sr;
    logic       alu_ss;
    logic [7:0] alu_out;
    logic       alu_cf;
    logic       alu_zf;

    logic [7:0] acc;
    logic       flag_c;
    logic       flag_z;
    logic       done;

    modport master (
        output cmd_valid, cmd_op, cmd_data, alu_out, alu_cf, alu_zf,
        input  cmd_ready, alu_a, alu_b, alu_ci, alu_nb, alu_ic, alu_na,
        input  alu_xo, alu_no, alu_sr, alu_ss, acc, flag_c, flag_z, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, alu_out, alu_cf, alu_zf,
        output cmd_ready, alu_a, alu_b, alu_ci, alu_nb, alu_ic, alu_na,
        output alu_xo, alu_no, alu_sr, alu_ss, acc, flag_c, flag_z, done
    );
endinterface

// File: rtl/alu_sequencer.sv
// Command sequencer in front of an 8-bit combinational ALU: owns the accumulator and C/Z flags,
// runs one ALU pass per command (one per bit for shifts) and pulses done on completion.
module alu_sequencer (
    input  logic          clk,
    input  logic          rst_n,
    alu_sequencer_if.slave bus
);

    localparam logic [3:0] OP_LD  = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_ADC = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_SBC = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_NOT = 4'h8;
    localparam logic [3:0] OP_INC = 4'h9;
    localparam logic [3:0] OP_DEC = 4'hA;
    localparam logic [3:0] OP_CMP = 4'hB;
    localparam logic [3:0] OP_SHR = 4'hC;
    localparam logic [3:0] OP_ASR = 4'hD;
    localparam logic [3:0] OP_NPE = 4'hE;
    localparam logic [3:0] OP_NPF = 4'hF;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t     state_r;
    state_t     state_s;
    logic [3:0] op_r;
    logic [3:0] op_s;
    logic [7:0] data_r;
    logic [7:0] data_s;
    logic [2:0] cnt_r;
    logic [2:0] cnt_s;
    logic [7:0] acc_r;
    logic [7:0] acc_s;
    logic       flag_c_r;
    logic       flag_c_s;
    logic       flag_z_r;
    logic       flag_z_s;
    logic       done_r;
    logic       done_s;
    logic       ready_r;

    logic [7:0] alu_a_s;
    logic [7:0] alu_b_s;
    logic       alu_ci_s;
    logic       alu_nb_s;
    logic       alu_ic_s;
    logic       alu_na_s;
    logic       alu_xo_s;
    logic       alu_no_s;
    logic       alu_sr_s;
    logic       alu_ss_s;

    function automatic logic writes_carry(input logic [3:0] op);
        case (op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_INC, OP_DEC, OP_CMP: writes_carry = 1'b1;
            default:                                                writes_carry = 1'b0;
        endcase
    endfunction

    function automatic logic is_shift(input logic [3:0] op);
        case (op)
            OP_SHR, OP_ASR: is_shift = 1'b1;
            default:        is_shift = 1'b0;
        endcase
    endfunction

    // ALU operand and control decode from state, latched op and accumulator.
    always_comb begin
        alu_a_s  = acc_r;
        alu_b_s  = 8'h00;
        alu_ci_s = 1'b0;
        alu_nb_s = 1'b0;
        alu_ic_s = 1'b0;
        alu_na_s = 1'b0;
        alu_xo_s = 1'b0;
        alu_no_s = 1'b0;
        alu_sr_s = 1'b0;
        alu_ss_s = 1'b0;
        if (state_r == EXEC) begin
            alu_b_s = data_r;
            case (op_r)
                OP_ADD: begin
                    alu_ci_s = 1'b0;
                end
                OP_ADC: begin
                    alu_ci_s = flag_c_r;
                end
                OP_SUB, OP_CMP: begin
                    alu_nb_s = 1'b1;
                    alu_ci_s = 1'b1;
                end
                OP_SBC: begin
                    alu_nb_s = 1'b1;
                    alu_ci_s = flag_c_r;
                end
                // a AND b realised as NOT(NOT a OR NOT b).
                OP_AND: begin
                    alu_na_s = 1'b1;
                    alu_nb_s = 1'b1;
                    alu_ic_s = 1'b1;
                    alu_xo_s = 1'b1;
                    alu_no_s = 1'b1;
                end
                OP_OR: begin
                    alu_ic_s = 1'b1;
                    alu_xo_s = 1'b1;
                end
                OP_XOR: begin
                    alu_ic_s = 1'b1;
                end
                OP_NOT: begin
                    alu_b_s  = 8'h00;
                    alu_na_s = 1'b1;
                    alu_ic_s = 1'b1;
                end
                OP_INC: begin
                    alu_b_s  = 8'h00;
                    alu_ci_s = 1'b1;
                end
                OP_DEC: begin
                    alu_b_s  = 8'h00;
                    alu_nb_s = 1'b1;
                end
                OP_SHR: begin
                    alu_b_s  = 8'h00;
                    alu_ic_s = 1'b1;
                    alu_sr_s = 1'b1;
                end
                OP_ASR: begin
                    alu_b_s  = 8'h00;
                    alu_ic_s = 1'b1;
                    alu_sr_s = 1'b1;
                    alu_ss_s = 1'b1;
                end
                default: begin
                    alu_ci_s = 1'b0;
                end
            endcase
        end else begin
            alu_b_s = 8'h00;
        end
    end

    // Next-state, command latch and writeback decision.
    always_comb begin
        state_s  = state_r;
        op_s     = op_r;
        data_s   = data_r;
        cnt_s    = cnt_r;
        acc_s    = acc_r;
        flag_c_s = flag_c_r;
        flag_z_s = flag_z_r;
        done_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.cmd_valid) begin
                    op_s    = bus.cmd_op;
                    data_s  = bus.cmd_data;
                    cnt_s   = bus.cmd_data[2:0];
                    state_s = EXEC;
                end else begin
                    state_s = IDLE;
                end
            end
            EXEC: begin
                // Intermediate shift passes write back and stay in EXEC.
                if (is_shift(op_r) && (cnt_r > 3'd1)) begin
                    acc_s    = bus.alu_out;
                    flag_z_s = bus.alu_zf;
                    cnt_s    = cnt_r - 3'd1;
                    state_s  = EXEC;
                end else begin
                    state_s = IDLE;
                    done_s  = 1'b1;
                    cnt_s   = 3'd0;
                    case (op_r)
                        OP_LD: begin
                            acc_s    = data_r;
                            flag_z_s = (data_r == 8'h00);
                        end
                        OP_CMP: begin
                            flag_z_s = bus.alu_zf;
                            flag_c_s = bus.alu_cf;
                        end
                        OP_SHR, OP_ASR: begin
                            if (cnt_r != 3'd0) begin
                                acc_s    = bus.alu_out;
                                flag_z_s = bus.alu_zf;
                            end else begin
                                acc_s = acc_r;
                            end
                        end
                        OP_NPE, OP_NPF: begin
                            acc_s = acc_r;
                        end
                        default: begin
                            acc_s    = bus.alu_out;
                            flag_z_s = bus.alu_zf;
                            flag_c_s = writes_carry(op_r) ? bus.alu_cf : flag_c_r;
                        end
                    endcase
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, command latch, accumulator, flags and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            op_r     <= 4'h0;
            data_r   <= 8'h00;
            cnt_r    <= 3'd0;
            acc_r    <= 8'h00;
            flag_c_r <= 1'b0;
            flag_z_r <= 1'b0;
            done_r   <= 1'b0;
            ready_r  <= 1'b1;
        end else begin
            state_r  <= state_s;
            op_r     <= op_s;
            data_r   <= data_s;
            cnt_r    <= cnt_s;
            acc_r    <= acc_s;
            flag_c_r <= flag_c_s;
            flag_z_r <= flag_z_s;
            done_r   <= done_s;
            ready_r  <= (state_s == IDLE);
        end
    end

    assign bus.cmd_ready = ready_r;
    assign bus.acc       = acc_r;
    assign bus.flag_c    = flag_c_r;
    assign bus.flag_z    = flag_z_r;
    assign bus.done      = done_r;
    assign bus.alu_a     = alu_a_s;
    assign bus.alu_b     = alu_b_s;
    assign bus.alu_ci    = alu_ci_s;
    assign bus.alu_nb    = alu_nb_s;
    assign bus.alu_ic    = alu_ic_s;
    assign bus.alu_na    = alu_na_s;
    assign bus.alu_xo    = alu_xo_s;
    assign bus.alu_no    = alu_no_s;
    assign bus.alu_sr    = alu_sr_s;
    assign bus.alu_ss    = alu_ss_s;

endmodule
